// File: rtl/warp_issue_arbiter_pkg.sv
// Shared types, default widths and the round-robin pick helper for the
// warp issue arbiter.
package warp_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_CNT_W   = 32;
  localparam int MAX_REQ     = 8;

  // Output register payload. Sized at the default widths, which are also the
  // largest AW/DW the arbiter supports.
  typedef struct packed {
    logic [DEF_AW-1:0]   addr;
    logic                is_write;
    logic [DEF_DW-1:0]   wdata;
    logic [DEF_DW/8-1:0] wstrb;
  } issue_req_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n.
  // Scans from the far end so the nearest hit is the one that sticks.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0] ptr,
                                       input int n);
    rr_pick_t   p;
    logic [3:0] j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = {1'b0, ptr} + 4'(k);
        if (j >= 4'(n)) j = j - 4'(n);
        if (valid[j[2:0]]) begin
          p.found = 1'b1;
          p.idx   = j[2:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/warp_issue_arbiter_if.sv
// Issue bus between the warp schedulers and the arbiter, plus the single
// downstream issue port toward the AXI bridge.
// master: scheduler / bridge side.  slave: the arbiter.
interface warp_issue_if import warp_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) ();
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*AW-1:0]       req_addr;
  logic [NUM_REQ-1:0]          req_is_write;
  logic [NUM_REQ*DW-1:0]       req_wdata;
  logic [NUM_REQ*(DW/8)-1:0]   req_wstrb;
  logic [NUM_REQ-1:0]          req_ready;

  logic                        out_valid;
  logic [AW-1:0]               out_addr;
  logic                        out_is_write;
  logic [DW-1:0]               out_wdata;
  logic [DW/8-1:0]             out_wstrb;
  logic [SRC_W-1:0]            out_src;
  logic                        out_ready;

  modport master (
    output req_valid, req_addr, req_is_write, req_wdata, req_wstrb, out_ready,
    input  req_ready, out_valid, out_addr, out_is_write, out_wdata, out_wstrb, out_src
  );

  modport slave (
    input  req_valid, req_addr, req_is_write, req_wdata, req_wstrb, out_ready,
    output req_ready, out_valid, out_addr, out_is_write, out_wdata, out_wstrb, out_src
  );

endinterface

// File: rtl/warp_issue_arbiter_rr_arbiter.sv
// Round-robin grant logic and its pointer register. The grant depends only
// on req_valid, rr_ptr and can_load, never on request payload.
module rr_arbiter import warp_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               can_load,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [SRC_W-1:0]   grant,
  output logic               accept
);

  logic [2:0] rr_ptr;
  rr_pick_t   pick;

  // Pick the winner and raise its ready only when the output slot can take it.
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_valid), rr_ptr, NUM_REQ);
    grant     = pick.idx[SRC_W-1:0];
    accept    = pick.found && can_load && !rst;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = accept && (pick.idx == 3'(i));
  end

  // Advance the pointer past the winner on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (pick.idx == 3'(NUM_REQ - 1)) ? 3'd0 : pick.idx + 3'd1;
  end

endmodule

// File: rtl/warp_issue_arbiter.sv
// Shares one memory issue port among NUM_REQ warp schedulers: round-robin
// grant, one-entry registered output slot, per-requester accept counters.
// Optional starvation monitor built when WARP_ARB_STARVE_EN is defined.
// AW and DW must not exceed the package defaults.
module warp_issue_arbiter import warp_arb_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  warp_issue_if.slave              bus,
  input  logic                     clr_counts,
  output logic [NUM_REQ*CNT_W-1:0] accept_count
`ifdef WARP_ARB_STARVE_EN
  ,
  output logic [NUM_REQ-1:0]       starve_flag
`endif
);

  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW    = DW / 8;

  logic             can_load;
  logic             accept;
  logic [SRC_W-1:0] grant;
  issue_req_t       slot_d, slot_q;
  logic             out_valid_q;
  logic [SRC_W-1:0] src_q;
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  assign can_load = !out_valid_q || bus.out_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .can_load  (can_load),
    .req_ready (bus.req_ready),
    .grant     (grant),
    .accept    (accept)
  );

  // Select the granted requester's payload for the output slot.
  always_comb begin
    slot_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == SRC_W'(i)) begin
        slot_d.addr     = DEF_AW'(bus.req_addr[i*AW +: AW]);
        slot_d.is_write = bus.req_is_write[i];
        slot_d.wdata    = DEF_DW'(bus.req_wdata[i*DW +: DW]);
        slot_d.wstrb    = (DEF_DW/8)'(bus.req_wstrb[i*SW +: SW]);
      end
    end
  end

  // Output slot: load on accept (also covers drain+load), else drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      slot_q      <= '0;
      src_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      slot_q      <= slot_d;
      src_q       <= grant;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_addr     = slot_q.addr[AW-1:0];
  assign bus.out_is_write = slot_q.is_write;
  assign bus.out_wdata    = slot_q.wdata[DW-1:0];
  assign bus.out_wstrb    = slot_q.wstrb[SW-1:0];
  assign bus.out_src      = src_q;

  // Accept counters; a clear in the same cycle as an accept wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (clr_counts) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant == SRC_W'(i)) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt_out
    assign accept_count[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end

`ifdef WARP_ARB_STARVE_EN
  logic [7:0]         wait_q [NUM_REQ];
  logic [NUM_REQ-1:0] starve_q;

  // Wait counters saturate at 255 so a long stall cannot wrap back under the mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i] || bus.req_ready[i])
          wait_q[i] <= '0;
        else if (wait_q[i] != 8'hFF)
          wait_q[i] <= wait_q[i] + 8'd1;
      end
      if (clr_counts)
        starve_q <= '0;
      else
        for (int i = 0; i < NUM_REQ; i++)
          if (wait_q[i] == 8'hFF) starve_q[i] <= 1'b1;
    end
  end

  assign starve_flag = starve_q;
`endif

endmodule

// File: tb/tb_warp_issue_arbiter.sv
module tb_warp_issue_arbiter;
  import warp_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst;
  logic clr_counts;
  logic [N*CW-1:0] accept_count;
`ifdef WARP_ARB_STARVE_EN
  logic [N-1:0] starve_flag;
`endif

  warp_issue_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

  warp_issue_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clr_counts   (clr_counts),
    .accept_count (accept_count)
`ifdef WARP_ARB_STARVE_EN
    ,
    .starve_flag  (starve_flag)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pointer, output slot contents, counters.
  int             m_ptr;
  bit             m_valid;
  logic [AW-1:0]  m_addr;
  logic           m_wr;
  logic [DW-1:0]  m_wdata;
  logic [SW-1:0]  m_wstrb;
  int             m_src;
  logic [CW-1:0]  m_cnt [N];
  int             m_acc;

  typedef struct {
    logic [N-1:0] v;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    int           exp_src;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_addr = '0; m_wr = 0; m_wdata = '0; m_wstrb = '0;
    m_src = 0; m_acc = -1;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  task automatic model_edge();
    int g;
    bit can;
    g = model_grant(bus.req_valid);
    can = !m_valid || bus.out_ready;
    m_acc = -1;
    if (g >= 0 && can) begin
      m_valid = 1;
      m_addr  = bus.req_addr[g*AW +: AW];
      m_wr    = bus.req_is_write[g];
      m_wdata = bus.req_wdata[g*DW +: DW];
      m_wstrb = bus.req_wstrb[g*SW +: SW];
      m_src   = g;
      m_ptr   = (g + 1) % N;
      m_cnt[g] = m_cnt[g] + 1;
      m_acc   = g;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
    if (clr_counts)
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    int g;
    bit can;
    logic [N-1:0] er;
    g = model_grant(bus.req_valid);
    can = !m_valid || bus.out_ready;
    er = '0;
    if (g >= 0 && can) er[g] = 1'b1;
    chk({tag, ".req_ready"}, bus.req_ready, er);
    chk({tag, ".out_valid"}, bus.out_valid, m_valid);
    if (m_valid) begin
      chk({tag, ".out_addr"}, bus.out_addr, m_addr);
      chk({tag, ".out_is_write"}, bus.out_is_write, m_wr);
      chk({tag, ".out_wdata"}, bus.out_wdata, m_wdata);
      chk({tag, ".out_wstrb"}, bus.out_wstrb, m_wstrb);
      chk({tag, ".out_src"}, bus.out_src, m_src);
    end
    for (int i = 0; i < N; i++)
      chk({tag, ".accept_count"}, accept_count[i*CW +: CW], m_cnt[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr_counts = 1'b0;
    bus.req_valid = '0;
    bus.req_is_write = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = 32'h1000 + i;
    bus.req_addr[2*AW +: AW] = 32'h8000_0010;
    model_reset();

    //                 v        ordy  exp_rdy  ov  src
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2};
    tbl[2]  = '{4'b1001, 1'b1, 4'b1000, 1'b0, 0};
    tbl[3]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 3};
    tbl[4]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 0};
    tbl[5]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 0};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

    // Reset state, with every requester asking.
    @(negedge clk);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst.out_valid", bus.out_valid, 1'b0);
    chk("rst.req_ready", bus.req_ready, 4'b0000);
    chk("rst.out_addr", bus.out_addr, 32'h0);
    chk("rst.out_src", bus.out_src, 2'd0);
    chk("rst.accept_count", accept_count, '0);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Table: single requester, wrap/skip fairness, backpressure, drain.
    for (int k = 0; k < 11; k++) begin
      bus.req_valid = tbl[k].v;
      bus.out_ready = tbl[k].ordy;
      #1;
      chk("tbl.req_ready", bus.req_ready, tbl[k].exp_rdy);
      chk("tbl.out_valid", bus.out_valid, tbl[k].exp_ov);
      if (tbl[k].exp_ov) chk("tbl.out_src", bus.out_src, tbl[k].exp_src);
      if (k == 1) begin
        chk("single.out_addr", bus.out_addr, 32'h8000_0010);
        chk("single.count2", accept_count[2*CW +: CW], 32'd1);
      end
      tick();
    end

    // Four continuous requesters after a fresh reset.
    for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = 32'h1000 + i;
    do_reset();
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      #1;
      if (k > 0) chk("rr4.out_src", bus.out_src, (k - 1) % N);
      if (k < 8) tick();
    end
    for (int i = 0; i < N; i++) chk("rr4.count", accept_count[i*CW +: CW], 32'd2);

    // Backpressure: output held, no grants, then a bubble-free reload.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp.req_ready", bus.req_ready, 4'b0000);
      chk("bp.out_addr", bus.out_addr, 32'h1003);
      chk("bp.out_src", bus.out_src, 2'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.reload_ready", bus.req_ready, 4'b0001);
    tick();
    #1;
    chk("bp.reload_valid", bus.out_valid, 1'b1);
    chk("bp.reload_src", bus.out_src, 2'd0);

    // Clear concurrent with an accept on requester 1.
    bus.req_valid = 4'b0010;
    clr_counts = 1'b1;
    #1;
    chk("clr.req_ready", bus.req_ready, 4'b0010);
    tick();
    clr_counts = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("clr.counts", accept_count, '0);
    chk("clr.out_src", bus.out_src, 2'd1);

    // Asynchronous reset while holding an output; pointer returns to 0.
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", bus.out_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    chk("arst.rr_ptr0", bus.req_ready, 4'b0001);
    tick();

    // Randomized traffic against the model; requesters hold until accepted.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(bus.req_valid[i] && m_acc != i)) begin
          bus.req_valid[i] = ($urandom_range(0, 1) == 1);
          bus.req_addr[i*AW +: AW] = $urandom();
          bus.req_is_write[i] = $urandom_range(0, 1) == 1;
          bus.req_wdata[i*DW +: DW] = $urandom();
          bus.req_wstrb[i*SW +: SW] = 4'($urandom_range(0, 15));
        end
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      clr_counts = ($urandom_range(0, 99) < 3);
      #1;
      check_all("rand");
      tick();
    end
    clr_counts = 1'b0;

`ifdef WARP_ARB_STARVE_EN
    // Starvation: requester 1 held off behind a stalled output.
    do_reset();
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    tick();
    bus.req_valid = 4'b0010;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (k == 100) chk("starve.early", starve_flag, 4'b0000);
      tick();
    end
    #1;
    chk("starve.set", starve_flag, 4'b0010);
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("starve.sticky", starve_flag, 4'b0010);
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    #1;
    chk("starve.clr", starve_flag, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/warp_issue_arbiter.md
Name: warp_issue_arbiter

Overview:
- Shares one memory issue port (toward the AXI bridge) among NUM_REQ warp schedulers.
- Round-robin arbitration, one-entry registered output stage, per-requester accepted-op counters.
- Sits between the warp schedulers and the AXI bridge. Each upstream port follows the scheduler's issue_* valid/ready convention.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8
- CNT_W, 32, width of each per-requester counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester issue valid
- req_addr  in  NUM_REQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_is_write  in  NUM_REQ  per-requester write flag
- req_wdata  in  NUM_REQ*DW  flattened write data
- req_wstrb  in  NUM_REQ*(DW/8)  flattened strobes
- req_ready  out  NUM_REQ  per-requester accept
- out_valid  out  1  downstream issue valid
- out_addr  out  AW  downstream address
- out_is_write  out  1  downstream write flag
- out_wdata  out  DW  downstream write data
- out_wstrb  out  DW/8  downstream strobe
- out_src  out  $clog2(NUM_REQ)  index of the requester that owns the current output
- out_ready  in  1  downstream accept
- clr_counts  in  1  synchronous clear of all accept counters
- accept_count  out  NUM_REQ*CNT_W  flattened per-requester accepted-op counts

Behaviour:
- Reset (rst=1, asynchronous): out_valid=0; out_addr, out_wdata, out_wstrb, out_src, out_is_write=0; rr_ptr=0; all accept_count=0; req_ready=0.
- Output slot:
  - can_load = !out_valid || out_ready.
  - Arbitration runs every cycle on the current req_valid.
- Round-robin grant:
  - Search starts at index rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 is granted.
  - req_ready[i] = (i==grant) && any_valid && can_load. At most one bit is set.
  - req_ready is purely combinational from req_valid, out_valid, out_ready and rr_ptr. There is no combinational path from req_addr/wdata.
- Handshake on req_valid[g] && req_ready[g]:
  - Next cycle: out_valid=1 and the out_* fields hold requester g's fields. out_src=g.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - accept_count[g] increments and wraps at 2^CNT_W.
- Downstream:
  - On out_valid && out_ready with no new accept: out_valid <= 0.
  - Drain and load in the same cycle: out_valid stays 1 and the fields are replaced. This gives 1 op/cycle sustained.
- While out_valid && !out_ready, all out_* fields are held stable and req_ready=0.
- Latency: accept to out_valid is 1 cycle.
- No requests valid: rr_ptr and counters hold.
- Upstream rule: a requester must hold valid and its fields stable until accepted. The arbiter does not check this.
- clr_counts=1: all counters go to 0 the next cycle. If an accept happens in the same cycle, clear wins and that accept is not counted.
- Reset mid-transfer: the in-flight output is dropped and out_valid goes low immediately.
- Fairness: with all NUM_REQ requesters continuously valid and out_ready=1, grants run 0,1,…,NUM_REQ-1,0,…

Optional Feature:
- Macro WARP_ARB_STARVE_EN.
- When defined:
  - Per-requester wait counter (8 bits), incremented each cycle that req_valid[i] && !req_ready[i]; cleared on accept or when req_valid[i]=0.
  - Extra output port starve_flag [NUM_REQ-1:0], sticky. Bit i sets when wait counter i reaches 255; cleared by clr_counts.
- When undefined: no counters and no starve_flag port.

Decomposition:
- Package warp_arb_pkg holds:
  - the default widths;
  - the function rr_pick(valid, ptr), returning grant index and found bit;
  - a typedef issue_req_t struct {addr, is_write, wdata, wstrb} used for the output register.
- One natural sub-module: rr_arbiter (combinational grant + rr_ptr register). The top holds the output slot and counters.

Test Plan:
- Single requester: req_valid=4'b0100, addr 0x8000_0010, out_ready=1.
  - Expected: req_ready=4'b0100 for one cycle, then out_valid=1, out_addr=0x8000_0010, out_src=2, accept_count[2]=1.
- All four valid continuously, out_ready=1, 8 cycles.
  - Expected: out_src sequence 0,1,2,3,0,1,2,3; every accept_count=2.
- Backpressure: out_ready=0 for 5 cycles after a load.
  - Expected: req_ready=0 and out_* stable throughout. When out_ready=1, the next granted op loads the same cycle with no bubble.
- Fairness skip: req_valid=4'b1001 with rr_ptr=1.
  - Expected: grant 3, then 0, then 3.
- clr_counts concurrent with an accept on requester 1.
  - Expected: all counts 0 next cycle. Reset asserted while out_valid=1: out_valid=0 asynchronously and rr_ptr=0.
- WARP_ARB_STARVE_EN defined: hold req_valid[1]=1 with out_ready=0 for 255 cycles.
  - Expected: starve_flag[1]=1, which persists until clr_counts.
